ultrasonic_display: RTL and testbench
=====================================

ULTRASONIC_DISPLAY -- requirements
Module: ultrasonic_display

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter SCAN_DIV, default 100_000, clocks per digit slot (1 kHz per digit at default).
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port distance_cm  input  10  measured distance in cm from the ultrasonic measurement stage.
REQ-006 The block SHALL have port dist_valid  input  1  one-cycle strobe qualifying distance_cm.
REQ-007 The block SHALL have port busy  output  1  high while a binary-to-BCD conversion runs.
REQ-008 The block SHALL have port bcd_out  output  16  last converted value, four BCD digits, [3:0] = units.
REQ-009 The block SHALL have port seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port an  output  4  active-low digit enables, an[0] = units digit.

Function
REQ-011 The converter SHALL be an FSM with states IDLE, SHIFT, DONE.
REQ-012 In IDLE, dist_valid=1 SHALL capture distance_cm into a 10-bit shift register, clear the BCD accumulator, and enter SHIFT on the next edge.
REQ-013 SHIFT SHALL perform exactly one shift-add-3 iteration per clock (add 3 to every BCD nibble >= 5, then shift left one bit) for 10 clocks, then enter DONE.
REQ-014 DONE SHALL load bcd_out from the accumulator and return to IDLE in one clock.
REQ-015 Latency SHALL be fixed: strobe at edge N -> bcd_out updated at edge N+12; busy high from edge N+1 through edge N+11 inclusive.
REQ-016 dist_valid while busy SHALL set a one-deep pending flag and store the sample; a later strobe while busy SHALL overwrite the stored sample (newest wins).
REQ-017 If pending is set on return to IDLE, conversion of the stored sample SHALL start as if strobed in that cycle, and pending SHALL clear.
REQ-018 All 10-bit inputs 0..1023 SHALL convert exactly; no clamping; digit 3 is 0 or 1.
REQ-019 A 16-bit-safe scan counter SHALL count 0..SCAN_DIV-1 and advance a 2-bit digit index on wrap; index SHALL wrap 3 -> 0.
REQ-020 an SHALL drive exactly one 0, at the bit given by the digit index, at all times after reset.
REQ-021 seg SHALL show the bcd_out nibble of the active digit via standard 7-segment code, dp always 1 (off).
REQ-022 Leading-zero blanking: a digit above the most significant nonzero digit SHALL output seg=8'hFF; digit 0 SHALL never blank (value 0 shows "0").
REQ-023 seg/an SHALL be registered; bcd_out change SHALL appear on seg no later than the next clock.
REQ-024 Nibble codes 10..15 cannot occur; decoder SHALL output 8'hFF for them.

Reset
REQ-025 While rst=0: state=IDLE, pending=0, busy=0, bcd_out=16'h0000, scan counter=0, digit index=0, seg=8'hFF, an=4'b1111.
REQ-026 After rst deasserts, the first clock SHALL show "0" on digit 0 (an=4'b1110, seg=8'hC0).
REQ-027 Reset asserted mid-conversion SHALL abort it; the discarded sample SHALL not reach bcd_out.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, default CLK_HZ/SCAN_DIV, and the 7-segment code constants for 0..9 and BLANK.
REQ-029 A single combinational sub-module seg7_decode (4-bit nibble + blank -> 8-bit seg) SHALL be instantiated once.

Verification
REQ-030 Reset release, no strobe -> an=1110, seg=8'hC0, bcd_out=0, busy=0.
REQ-031 Strobe distance_cm=1023 -> busy high 11 cycles, bcd_out=16'h1023 at N+12; digits show 1,0,2,3.
REQ-032 Strobe 57 -> bcd_out=16'h0057; with SCAN_DIV=4, digits 3 and 2 seg=8'hFF, digit 1 = 8'h92, digit 0 = 8'hF8.
REQ-033 Strobe 300, then 200 and 45 during busy -> bcd_out=16'h0300 then 16'h0045; 200 never appears.
REQ-034 SCAN_DIV=4 -> an sequence 1110,1101,1011,0111,1110 changing every 4 clocks.
REQ-035 Strobe 512, assert rst at N+5 -> all outputs at REQ-025 values; after release bcd_out=0.

Source files
------------

// File: rtl/ultrasonic_display_pkg.sv
// Shared types and constants for the ultrasonic distance display:
// converter state encoding, default timing parameters and 7-segment codes.
package ultrasonic_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int DEFAULT_CLK_HZ   = 100_000_000;
  localparam int DEFAULT_SCAN_DIV = 100_000;
  localparam int BIN_WIDTH        = 10;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Double-dabble correction step applied to all four BCD nibbles.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] acc);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/ultrasonic_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder with blanking.
module seg7_decode
  import ultrasonic_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ultrasonic_display.sv
// Distance display: serial binary-to-BCD converter feeding a multiplexed
// four-digit 7-segment driver with leading-zero blanking.
module ultrasonic_display
  import ultrasonic_display_pkg::*;
#(
  parameter int CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  distance_cm,
  input  logic        dist_valid,
  output logic        busy,
  output logic [15:0] bcd_out,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  // A digit slot longer than one second is useless, so clamp to CLK_HZ;
  // the counter is sized from the slot length so the 100k default fits.
  localparam int SLOT_CLKS = (SCAN_DIV > CLK_HZ) ? CLK_HZ : SCAN_DIV;
  localparam int SCAN_W    = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SLOT_CLKS - 1);

  logic                 in_valid_reg;
  logic [BIN_WIDTH-1:0] in_data_reg;
  conv_state_t          state_reg, state_next;
  logic [BIN_WIDTH-1:0] bin_reg, bin_next;
  logic [15:0]          acc_reg, acc_next, adj;
  logic [3:0]           cnt_reg, cnt_next;
  logic                 pend_reg, pend_next;
  logic [BIN_WIDTH-1:0] pend_data_reg, pend_data_next;
  logic [15:0]          bcd_reg, bcd_next;

  // Strobe is registered first; this stage sets the fixed 12-clock latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_reg  <= 1'b0;
      in_data_reg   <= '0;
      state_reg     <= ST_IDLE;
      bin_reg       <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
      bcd_reg       <= '0;
    end else begin
      in_valid_reg  <= dist_valid;
      in_data_reg   <= distance_cm;
      state_reg     <= state_next;
      bin_reg       <= bin_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      pend_reg      <= pend_next;
      pend_data_reg <= pend_data_next;
      bcd_reg       <= bcd_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bin_next       = bin_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    pend_next      = pend_reg;
    pend_data_next = pend_data_reg;
    bcd_next       = bcd_reg;
    adj            = add3_nibbles(acc_reg);
    case (state_reg)
      ST_IDLE: begin
        if (in_valid_reg || pend_reg) begin
          bin_next   = in_valid_reg ? in_data_reg : pend_data_reg;
          acc_next   = '0;
          cnt_next   = '0;
          pend_next  = 1'b0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_next, bin_next} = {adj, bin_reg} << 1;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd9) state_next = ST_DONE;
      end
      ST_DONE: begin
        bcd_next   = acc_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Newest sample wins; it is picked up when the converter frees up.
    if (state_reg != ST_IDLE && in_valid_reg) begin
      pend_next      = 1'b1;
      pend_data_next = in_data_reg;
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign bcd_out = bcd_reg;

  logic [SCAN_W-1:0] scan_reg;
  logic [1:0]        digit_reg;
  logic [7:0]        seg_reg;
  logic [3:0]        an_reg;
  logic [3:0]        nibble;
  logic              blank;
  logic [7:0]        seg_code;

  // A digit blanks when it and everything above it is zero; digit 0 never blanks.
  assign nibble = bcd_reg[{digit_reg, 2'b00} +: 4];
  assign blank  = (digit_reg != 2'd0) && ((bcd_reg >> {digit_reg, 2'b00}) == 16'd0);

  seg7_decode u_seg7_decode (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_reg  <= '0;
      digit_reg <= 2'd0;
      seg_reg   <= SEG_BLANK;
      an_reg    <= 4'b1111;
    end else begin
      if (scan_reg == SCAN_MAX) begin
        scan_reg  <= '0;
        digit_reg <= digit_reg + 2'd1;
      end else begin
        scan_reg <= scan_reg + 1'b1;
      end
      seg_reg <= seg_code;
      an_reg  <= ~(4'b0001 << digit_reg);
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_ultrasonic_display.sv
// Scoreboard bench for ultrasonic_display: stimulus queues expected BCD
// results, a monitor checks them when each conversion completes.
module tb_ultrasonic_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  distance_cm = '0;
  logic        dist_valid = 1'b0;
  logic        busy;
  logic [15:0] bcd_out;
  logic [7:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] bcd;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  ultrasonic_display #(
    .CLK_HZ   (100_000_000),
    .SCAN_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .distance_cm (distance_cm),
    .dist_valid  (dist_valid),
    .busy        (busy),
    .bcd_out     (bcd_out),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one strobe at the current negedge; edge_n is the sampling edge.
  task automatic strobe(input logic [9:0] v, output int edge_n);
    distance_cm = v;
    dist_valid  = 1'b1;
    edge_n      = cyc + 1;
    @(negedge clk);
    dist_valid  = 1'b0;
    $display("strobe: distance_cm=%0d at edge %0d", v, edge_n);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic check_digit(input int idx, input logic [7:0] exp_seg);
    logic [3:0] want;
    int n = 0;
    want = ~(4'b0001 << idx);
    while (an !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("an_digit%0d", idx), an, want);
    check($sformatf("seg_digit%0d", idx), seg, exp_seg);
    $display("display: digit %0d an=%b seg=%h", idx, an, seg);
  endtask

  // Monitor: a falling busy edge marks a completed conversion.
  initial begin : monitor
    int   busy_len;
    exp_t e;
    busy_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_len = 0;
      end else if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got bcd_out=%h, expected no conversion", bcd_out);
        end else begin
          e = sb.pop_front();
          check("bcd_out", bcd_out, e.bcd);
          check("latency_edge", cyc, e.done_cyc);
          check("busy_cycles", busy_len, 11);
          $display("result: bcd_out=%h at edge %0d busy %0d cycles", bcd_out, cyc, busy_len);
        end
        busy_len = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, m;
    logic [3:0] exp_an;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_seg", seg, 8'hFF);
    check("rst_an", an, 4'b1111);
    rst = 1'b1;

    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("an_sequence", an, exp_an);
      if (k == 1) begin
        check("release_seg", seg, 8'hC0);
        check("release_bcd", bcd_out, 16'h0000);
        check("release_busy", busy, 1'b0);
      end
    end

    strobe(10'd1023, n);
    sb.push_back('{bcd: 16'h1023, done_cyc: n + 12});
    wait_drain();
    check_digit(3, 8'hF9);
    check_digit(2, 8'hC0);
    check_digit(1, 8'hA4);
    check_digit(0, 8'hB0);

    strobe(10'd57, n);
    sb.push_back('{bcd: 16'h0057, done_cyc: n + 12});
    wait_drain();
    check_digit(3, 8'hFF);
    check_digit(2, 8'hFF);
    check_digit(1, 8'h92);
    check_digit(0, 8'hF8);

    strobe(10'd1000, n);
    sb.push_back('{bcd: 16'h1000, done_cyc: n + 12});
    wait_drain();
    check_digit(3, 8'hF9);
    check_digit(1, 8'hC0);

    strobe(10'd0, n);
    sb.push_back('{bcd: 16'h0000, done_cyc: n + 12});
    wait_drain();
    check_digit(1, 8'hFF);
    check_digit(0, 8'hC0);

    // 200 is overwritten by 45 while the 300 conversion runs.
    strobe(10'd300, n);
    sb.push_back('{bcd: 16'h0300, done_cyc: n + 12});
    sb.push_back('{bcd: 16'h0045, done_cyc: n + 24});
    repeat (2) @(negedge clk);
    strobe(10'd200, m);
    strobe(10'd45, m);
    wait_drain();

    strobe(10'd512, n);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_seg", seg, 8'hFF);
    check("abort_an", an, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("after_abort_bcd", bcd_out, 16'h0000);
    check("after_abort_busy", busy, 1'b0);
    check("after_abort_queue", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
